// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the parametrised SPI slave.
//   spi_mode_t         : SPI mode encoding {CPOL, CPHA}
//   mode_cpol/mode_cpha: field extraction from a mode
//   SPI_MIN_SYNC       : lowest legal synchroniser depth
//   bitcnt_w           : bit-counter width for a given word width
package spi_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  localparam int SPI_MIN_SYNC = 2;

  function automatic logic mode_cpol(spi_mode_t m);
    logic [1:0] b;
    b = m;
    return b[1];
  endfunction

  function automatic logic mode_cpha(spi_mode_t m);
    logic [1:0] b;
    b = m;
    return b[0];
  endfunction

  // Counter indexes bits 0..data_w-1; never narrower than one bit.
  function automatic int bitcnt_w(int data_w);
    return (data_w > 2) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-deep synchroniser for an asynchronous pin, followed by
// one edge-detect flop.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronised level
//   rise/fall: single-cycle pulses on synchronised transitions
// RST_VAL sets the reset level of every flop so that reset itself never
// manufactures an edge on the chosen idle level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave with configurable word width, mode and bit order.
//   clk, rst          : system clock, synchronous active-high reset
//   SCK, SSEL, MOSI   : asynchronous SPI pins (SSEL active low)
//   MISO, miso_oe     : registered slave data out and its tri-state enable
//   tx_data/valid/ready: one-deep holding register feeding the shifter
//   rx_data, rx_valid : last complete word, one-cycle update pulse
//   tx_underrun       : pulse when TX_DEFAULT is loaded for lack of data
//   frame_abort       : pulse when SSEL deasserts mid-word
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter bit                CPOL        = 1'b0,
  parameter bit                CPHA        = 1'b0,
  parameter bit                LSB_FIRST   = 1'b0,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_DEFAULT  = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              SSEL,
  input  logic              MOSI,
  output logic              MISO,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam spi_mode_t MODE = spi_mode_t'({CPOL, CPHA});
  localparam bit        POL  = mode_cpol(MODE);
  localparam bit        PHA  = mode_cpha(MODE);
  localparam int        BCW  = bitcnt_w(DATA_W);
  localparam int        SS   = (SYNC_STAGES < SPI_MIN_SYNC) ? SPI_MIN_SYNC : SYNC_STAGES;

  // ---- input conditioning ----
  logic sck_q, sck_rise, sck_fall;
  logic ssel_q, ssel_rise, ssel_fall;
  logic [SS-1:0] mosi_sync;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SS), .RST_VAL(POL)) u_sck (
    .clk(clk), .rst(rst), .d(SCK), .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );

  // Resetting to "selected" means a reset taken while SSEL is held low
  // cannot fake a falling edge; the slave waits for a genuine new frame.
  spi_sync_edge #(.STAGES(SS), .RST_VAL(1'b0)) u_ssel (
    .clk(clk), .rst(rst), .d(SSEL), .q(ssel_q), .rise(ssel_rise), .fall(ssel_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[SS-2:0], MOSI};
  end
  assign mosi_s = mosi_sync[SS-1];

  // Lead edge leaves the idle level, trail edge returns to it.
  logic sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  assign sck_edge    = sck_rise | sck_fall;
  assign lead_edge   = sck_edge & (sck_q != POL);
  assign trail_edge  = sck_edge & (sck_q == POL);
  assign sample_edge = PHA ? trail_edge : lead_edge;
  assign shift_edge  = PHA ? lead_edge  : trail_edge;

  // ---- frame control and receive path ----
  logic             active;
  logic [BCW-1:0]   bitcnt;
  logic [DATA_W-1:0] rx_shift;
  logic             rx_done;    // word complete; publish next cycle
  logic             last_done;  // last bit sampled, its shift edge not yet seen
  logic             last_bit;

  assign last_bit = (bitcnt == BCW'(DATA_W-1));
  assign miso_oe  = active;

  always_ff @(posedge clk) begin
    if (rst) begin
      active      <= 1'b0;
      bitcnt      <= '0;
      rx_shift    <= '0;
      rx_done     <= 1'b0;
      last_done   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= rx_done;
      rx_done     <= 1'b0;
      frame_abort <= 1'b0;
      if (rx_done) rx_data <= rx_shift;
      if (ssel_fall) begin
        active    <= 1'b1;
        bitcnt    <= '0;
        last_done <= 1'b0;
      end else if (ssel_q) begin
        active    <= 1'b0;
        bitcnt    <= '0;
        last_done <= 1'b0;
        if (ssel_rise && bitcnt != '0) frame_abort <= 1'b1;
      end else if (active) begin
        if (shift_edge) last_done <= 1'b0;
        if (sample_edge) begin
          rx_shift <= LSB_FIRST ? {mosi_s, rx_shift[DATA_W-1:1]}
                                : {rx_shift[DATA_W-2:0], mosi_s};
          if (last_bit) begin
            bitcnt    <= '0;
            rx_done   <= 1'b1;
            last_done <= 1'b1;
          end else begin
            bitcnt <= bitcnt + BCW'(1);
          end
        end
      end
    end
  end

  // ---- transmit path ----
  logic [DATA_W-1:0] hold, tx_shift;
  logic              hold_full, hold_full_nxt, wr, ld;

  assign wr = tx_valid & tx_ready;

  // CPHA=0 must present bit 0 before the first sampling edge, so it loads at
  // frame start and on the trailing edge that closes each word.
  always_comb begin
    ld = 1'b0;
    if (PHA) ld = active & shift_edge & (bitcnt == '0);
    else     ld = ssel_fall | (active & shift_edge & last_done);
  end

  // The load sees the pre-write state; tx_ready mirrors !hold_full, so a
  // write can only land in an empty register.
  always_comb begin
    hold_full_nxt = hold_full;
    if (ld) hold_full_nxt = 1'b0;
    if (wr) hold_full_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold        <= '0;
      hold_full   <= 1'b0;
      tx_ready    <= 1'b0;
      tx_shift    <= '0;
      tx_underrun <= 1'b0;
      MISO        <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (ld) begin
        if (hold_full) begin
          tx_shift <= hold;
        end else begin
          tx_shift    <= TX_DEFAULT;
          tx_underrun <= 1'b1;
        end
      end else if (active && shift_edge) begin
        tx_shift <= LSB_FIRST ? {1'b0, tx_shift[DATA_W-1:1]}
                              : {tx_shift[DATA_W-2:0], 1'b0};
      end
      if (wr) hold <= tx_data;
      hold_full <= hold_full_nxt;
      tx_ready  <= !hold_full_nxt;
      MISO      <= active & (LSB_FIRST ? tx_shift[0] : tx_shift[DATA_W-1]);
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Three slaves share one SPI master: 0 = mode 0 / 8 bit / MSB first,
// 1 = mode 3 / 8 bit / MSB first, 2 = mode 1 / 16 bit / LSB first.
// Each has its own SSEL; SCK is inverted for the CPOL=1 slave.
module tb_spi_slave_param;

  localparam int HALF = 8;  // clk cycles per SCK half period

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck_b = 1'b0;
  logic mosi = 1'b0;
  logic [2:0] ssel = 3'b111;
  logic [2:0] tx_valid = 3'b000;
  logic [2:0][31:0] tdat = '0;

  wire [2:0] miso, oe, rdy, rxv, udr, abt;
  wire [7:0]  rxd0, rxd1;
  wire [15:0] rxd2;

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0)) u_d0 (
    .clk(clk), .rst(rst), .SCK(sck_b), .SSEL(ssel[0]), .MOSI(mosi),
    .MISO(miso[0]), .miso_oe(oe[0]), .tx_data(tdat[0][7:0]), .tx_valid(tx_valid[0]),
    .tx_ready(rdy[0]), .rx_data(rxd0), .rx_valid(rxv[0]), .tx_underrun(udr[0]),
    .frame_abort(abt[0]));

  spi_slave_param #(.DATA_W(8), .CPOL(1), .CPHA(1), .LSB_FIRST(0)) u_d1 (
    .clk(clk), .rst(rst), .SCK(~sck_b), .SSEL(ssel[1]), .MOSI(mosi),
    .MISO(miso[1]), .miso_oe(oe[1]), .tx_data(tdat[1][7:0]), .tx_valid(tx_valid[1]),
    .tx_ready(rdy[1]), .rx_data(rxd1), .rx_valid(rxv[1]), .tx_underrun(udr[1]),
    .frame_abort(abt[1]));

  spi_slave_param #(.DATA_W(16), .CPOL(0), .CPHA(1), .LSB_FIRST(1)) u_d2 (
    .clk(clk), .rst(rst), .SCK(sck_b), .SSEL(ssel[2]), .MOSI(mosi),
    .MISO(miso[2]), .miso_oe(oe[2]), .tx_data(tdat[2][15:0]), .tx_valid(tx_valid[2]),
    .tx_ready(rdy[2]), .rx_data(rxd2), .rx_valid(rxv[2]), .tx_underrun(udr[2]),
    .frame_abort(abt[2]));

  // ---- reference model state ----
  logic [31:0] hold_q[3][$];  // words accepted but not yet loaded
  logic [31:0] exp_rx[3][$];  // words the slave must publish, in order
  int exp_udr[3], obs_udr[3], exp_abt[3], obs_abt[3];
  int checks = 0, errors = 0;

  function automatic int wid(int k);
    return (k == 2) ? 16 : 8;
  endfunction

  function automatic logic [31:0] wmask(int k);
    return (k == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] rx_word(int k);
    case (k)
      0:       return {24'h0, rxd0};
      1:       return {24'h0, rxd1};
      default: return {16'h0, rxd2};
    endcase
  endfunction

  // A load takes the oldest accepted word, or the all-ones default.
  function automatic logic [31:0] model_load(int k);
    if (hold_q[k].size() != 0) return hold_q[k].pop_front();
    exp_udr[k]++;
    return wmask(k);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (udr[k]) obs_udr[k]++;
        if (abt[k]) obs_abt[k]++;
        if (rxv[k]) begin
          chk($sformatf("rx_pending%0d", k), 32'(exp_rx[k].size() != 0), 32'd1);
          if (exp_rx[k].size() != 0)
            chk($sformatf("rx_data%0d", k), rx_word(k), exp_rx[k].pop_front());
        end
      end
    end
  endtask

  task automatic wr_tx(input int k, input logic [31:0] d);
    int n = 0;
    while (!rdy[k] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("tx_ready_wait%0d", k), 32'(rdy[k]), 32'd1);
    if (rdy[k]) begin
      tdat[k] = d;
      tx_valid[k] = 1'b1;
      hold_q[k].push_back(d & wmask(k));
      @(negedge clk);
      tx_valid[k] = 1'b0;
    end
  endtask

  task automatic frame_begin(input int k, output logic [31:0] nxt);
    nxt = '0;
    if (k == 0) nxt = model_load(k);  // CPHA=0 loads at frame start
    @(negedge clk);
    ssel[k] = 1'b0;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic frame_end(input int k);
    repeat (HALF) @(negedge clk);
    ssel[k] = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  // Master side of one word (or nbits of it). et carries the word the slave
  // is expected to shift out.
  task automatic xfer(input int k, input logic [31:0] dout, input int nbits,
                      inout logic [31:0] et);
    logic [31:0] cap;
    int b;
    cap = '0;
    if (nbits == wid(k)) exp_rx[k].push_back(dout & wmask(k));
    if (k != 0) et = model_load(k);   // CPHA=1 loads on each word's first edge
    for (int i = 0; i < nbits; i++) begin
      b = (k == 2) ? i : wid(k) - 1 - i;
      if (k == 0) begin
        mosi = dout[b];
        repeat (HALF) @(negedge clk);
        sck_b = 1'b1;
        cap[b] = miso[k];
        repeat (HALF) @(negedge clk);
        sck_b = 1'b0;
      end else begin
        sck_b = 1'b1;
        mosi = dout[b];
        repeat (HALF) @(negedge clk);
        sck_b = 1'b0;
        cap[b] = miso[k];
        repeat (HALF) @(negedge clk);
      end
    end
    if (nbits == wid(k)) begin
      chk($sformatf("miso_word%0d", k), cap, et & wmask(k));
      if (k == 0) et = model_load(k);  // closing trailing edge reloads
    end
  endtask

  initial begin
    logic [31:0] et;
    logic [31:0] rw;
    fork monitor(); join_none

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {14'h0, miso, oe, rdy, rxv, udr, abt}, 32'h0);
    chk("reset_rx_data", {rxd2, rxd1, rxd0}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("tx_ready_after_reset", {29'h0, rdy}, 32'h7);
    chk("idle_miso_oe", {26'h0, miso, oe}, 32'h0);

    // mode 0: preload 0x3C, receive 0xA5; refill so the end-of-word load is fed
    wr_tx(0, 32'h3C);
    frame_begin(0, et);
    fork
      wr_tx(0, 32'hC3);
      xfer(0, 32'hA5, 8, et);
    join
    frame_end(0);
    chk("mode0_underruns", obs_udr[0], exp_udr[0]);

    // mode 3: two words in one frame, second tx word written on tx_ready
    wr_tx(1, 32'h81);
    frame_begin(1, et);
    fork
      wr_tx(1, 32'h7E);
      begin
        xfer(1, 32'h12, 8, et);
        xfer(1, 32'h34, 8, et);
      end
    join
    frame_end(1);
    chk("mode3_underruns", obs_udr[1], exp_udr[1]);

    // underrun: random words, nothing written
    frame_begin(1, et);
    for (int i = 0; i < 2; i++) begin
      rw = 32'($urandom_range(0, 255));
      xfer(1, rw, 8, et);
    end
    frame_end(1);
    chk("underrun_count", obs_udr[1], exp_udr[1]);

    // abort after 5 bits, then a clean 0x5A frame
    frame_begin(0, et);
    xfer(0, 32'h33, 5, et);
    exp_abt[0]++;
    frame_end(0);
    chk("abort_count", obs_abt[0], exp_abt[0]);
    frame_begin(0, et);
    xfer(0, 32'h5A, 8, et);
    frame_end(0);
    chk("abort_no_extra", obs_abt[0], exp_abt[0]);

    // mode 1, 16 bit, LSB first; then a random word
    wr_tx(2, 32'h1234);
    frame_begin(2, et);
    xfer(2, 32'hBEEF, 16, et);
    frame_end(2);
    rw = 32'($urandom_range(0, 65535));
    wr_tx(2, rw ^ 32'h0000_FFFF);
    frame_begin(2, et);
    xfer(2, rw, 16, et);
    frame_end(2);
    chk("lsb16_underruns", obs_udr[2], exp_udr[2]);

    // reset mid-word
    wr_tx(0, 32'hA0);
    frame_begin(0, et);
    xfer(0, 32'h77, 3, et);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", {14'h0, miso, oe, rdy, rxv, udr, abt}, 32'h0);
    chk("midreset_rx_data", {rxd2, rxd1, rxd0}, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) hold_q[k].delete();
    @(negedge clk);
    chk("tx_ready_after_midreset", {29'h0, rdy}, 32'h7);
    ssel[0] = 1'b1;
    repeat (2*HALF) @(negedge clk);
    wr_tx(0, 32'h96);
    frame_begin(0, et);
    xfer(0, 32'h69, 8, et);
    frame_end(0);

    // totals
    repeat (4*HALF) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("underrun_total%0d", k), obs_udr[k], exp_udr[k]);
      chk($sformatf("abort_total%0d", k), obs_abt[k], exp_abt[k]);
      chk($sformatf("rx_leftover%0d", k), exp_rx[k].size(), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
